// File: rtl/ahb_si_arbiter_pkg.sv
// AHB slave-port arbiter shared types: HTRANS/HBURST encodings,
// arbiter state enum and the fixed-burst beat-count helper.
package AHB_package;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    BR_SINGLE = 3'd0,
    BR_INCR   = 3'd1,
    BR_WRAP4  = 3'd2,
    BR_INCR4  = 3'd3,
    BR_WRAP8  = 3'd4,
    BR_INCR8  = 3'd5,
    BR_WRAP16 = 3'd6,
    BR_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2,
    ST_LOCK  = 2'd3
  } arb_state_t;

  // SEQ beats still to come after the NONSEQ of a fixed burst
  function automatic logic [3:0] burst_beats(hburst_t b);
    case (b)
      BR_WRAP4, BR_INCR4:   burst_beats = 4'd3;
      BR_WRAP8, BR_INCR8:   burst_beats = 4'd7;
      BR_WRAP16, BR_INCR16: burst_beats = 4'd15;
      default:              burst_beats = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_si_arbiter_pick.sv
// Rotating one-hot picker: first set req bit searching upward
// (wrapping) from last_grant+1.
module ahb_rr_pick #(
  parameter int N  = 2,
  parameter int MW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] last_grant,
  output logic [N-1:0]  grant
);

  logic w_found;
  int   w_j;

  // scan N positions starting just above the previous winner
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int i = 1; i <= N; i++) begin
      w_j = int'(last_grant) + i;
      if (w_j >= N) w_j = w_j - N;
      if (!w_found && req[w_j[MW-1:0]]) begin
        grant[w_j[MW-1:0]] = 1'b1;
        w_found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_si_arbiter.sv
// AHB slave-interface arbiter: round-robin owner select with burst
// hold; locked sequences only when AHB_ARB_LOCK_EN is defined.
module ahb_si_arbiter
  import AHB_package::*;
#(
  parameter int MASTER_NUM = 2,
  parameter int MW         = $clog2(MASTER_NUM)
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [MASTER_NUM-1:0]      hreq,
  input  logic [MASTER_NUM-1:0][1:0] htrans,
  input  logic [MASTER_NUM-1:0][2:0] hburst,
  input  logic [MASTER_NUM-1:0]      hlock,
  input  logic                       hready,
  output logic [MASTER_NUM-1:0]      addr_sel,
  output logic [MASTER_NUM-1:0]      data_sel,
  output logic [MW-1:0]              hmaster,
  output logic                       hmastlock
);

`ifdef AHB_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  arb_state_t            r_state, w_state;
  logic [3:0]            r_cnt, w_cnt;
  logic                  r_fixed, w_fixed;
  logic [MW-1:0]         r_owner, w_owner;
  logic [MW-1:0]         r_last, w_last;
  logic [MASTER_NUM-1:0] r_addr_sel, w_sel;
  logic [MASTER_NUM-1:0] r_data_sel;
  logic [MASTER_NUM-1:0] w_grant;
  logic [MW-1:0]         w_gidx;
  logic                  w_open;
  htrans_t               w_tr;
  hburst_t               w_bu;
  logic                  w_lk;

  ahb_rr_pick #(
    .N  (MASTER_NUM),
    .MW (MW)
  ) u_pick (
    .req        (hreq),
    .last_grant (r_last),
    .grant      (w_grant)
  );

  assign w_tr = htrans_t'(htrans[r_owner]);
  assign w_bu = hburst_t'(hburst[r_owner]);
  assign w_lk = LOCK_EN & hlock[r_owner];

  assign addr_sel  = r_addr_sel;
  assign data_sel  = r_data_sel;
  assign hmaster   = r_owner;
  assign hmastlock = (r_state != ST_IDLE) & w_lk;

  // one-hot winner to binary index
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < MASTER_NUM; i++)
      if (w_grant[i]) w_gidx = MW'(i);
  end

  // next state: decide whether this accepted edge is an arbitration point
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_fixed = r_fixed;
    w_owner = r_owner;
    w_last  = r_last;
    w_sel   = r_addr_sel;
    w_open  = 1'b0;
    if (hready) begin
      unique case (r_state)
        ST_IDLE, ST_OWN: w_open = 1'b1;
        ST_BURST: begin
          unique case (w_tr)
            TR_SEQ: begin
              if (r_fixed) begin
                if (r_cnt <= 4'd1) w_open = 1'b1;
                else w_cnt = r_cnt - 4'd1;
              end
            end
            TR_BUSY: w_open = 1'b0;
            default: w_open = 1'b1;
          endcase
        end
        ST_LOCK: begin
          if (!w_lk && (w_tr == TR_NONSEQ || w_tr == TR_SEQ))
            w_open = 1'b1;
        end
        default: w_open = 1'b1;
      endcase
      if (w_open) begin
        w_cnt   = 4'd0;
        w_fixed = 1'b0;
        if (r_state != ST_IDLE && w_tr == TR_NONSEQ && w_lk) begin
          w_state = ST_LOCK;
        end else if (r_state != ST_IDLE && w_tr == TR_NONSEQ &&
                     w_bu != BR_SINGLE) begin
          w_state = ST_BURST;
          w_cnt   = burst_beats(w_bu);
          w_fixed = (w_bu != BR_INCR);
        end else if (|hreq) begin
          w_state = ST_OWN;
          w_sel   = w_grant;
          w_owner = w_gidx;
          w_last  = w_gidx;
        end else begin
          w_state = ST_IDLE;
          w_sel   = '0;
          w_owner = '0;
        end
      end
    end
  end

  // state registers; data select trails address select by one accepted edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_fixed    <= 1'b0;
      r_owner    <= '0;
      r_last     <= MW'(MASTER_NUM - 1);
      r_addr_sel <= '0;
      r_data_sel <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_fixed    <= w_fixed;
      r_owner    <= w_owner;
      r_last     <= w_last;
      r_addr_sel <= w_sel;
      if (hready) r_data_sel <= r_addr_sel;
    end
  end

endmodule

// File: tb/tb_ahb_si_arbiter.sv
// Bench for ahb_si_arbiter (2 masters); expected selects are queued
// per driven cycle and popped after the clock edge.
module tb_ahb_si_arbiter;
  import AHB_package::*;

  localparam logic [1:0] I  = 2'd0;
  localparam logic [1:0] B  = 2'd1;
  localparam logic [1:0] NS = 2'd2;
  localparam logic [1:0] S  = 2'd3;
  localparam logic [2:0] SG = 3'd0;
  localparam logic [2:0] IC = 3'd1;
  localparam logic [2:0] I4 = 3'd3;
  localparam logic [2:0] I8 = 3'd5;
  localparam logic [2:0] IX = 3'd7;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [1:0]      hreq;
  logic [1:0][1:0] htrans;
  logic [1:0][2:0] hburst;
  logic [1:0]      hlock;
  logic            hready;
  logic [1:0]      addr_sel;
  logic [1:0]      data_sel;
  logic            hmaster;
  logic            hmastlock;

  ahb_si_arbiter #(.MASTER_NUM(2)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .hreq      (hreq),
    .htrans    (htrans),
    .hburst    (hburst),
    .hlock     (hlock),
    .hready    (hready),
    .addr_sel  (addr_sel),
    .data_sel  (data_sel),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string      tag;
    logic [1:0] a;
    logic [1:0] d;
    logic       m;
    logic       ml;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] rq,
                      input logic [1:0] t0, input logic [2:0] b0,
                      input logic [1:0] t1, input logic [2:0] b1,
                      input logic [1:0] lk, input logic rdy,
                      input logic [1:0] ea, input logic [1:0] ed,
                      input logic eml);
    exp_t e;
    @(negedge HCLK);
    hreq      = rq;
    htrans[0] = t0;
    hburst[0] = b0;
    htrans[1] = t1;
    hburst[1] = b1;
    hlock     = lk;
    hready    = rdy;
    e.tag = tag;
    e.a   = ea;
    e.d   = ed;
    e.m   = ea[1];
    e.ml  = eml;
    sbq.push_back(e);
    @(posedge HCLK);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, ".sbq"}, 32'(0), 32'(1));
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".addr"}, 32'(addr_sel), 32'(e.a));
      chk({e.tag, ".data"}, 32'(data_sel), 32'(e.d));
      chk({e.tag, ".hm"}, 32'(hmaster), 32'(e.m));
      chk({e.tag, ".lock"}, 32'(hmastlock), 32'(e.ml));
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".addr"}, 32'(addr_sel), 32'(0));
    chk({tag, ".data"}, 32'(data_sel), 32'(0));
    chk({tag, ".hm"}, 32'(hmaster), 32'(0));
    chk({tag, ".lock"}, 32'(hmastlock), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    hreq    = 2'b11;
    htrans  = '0;
    hburst  = '0;
    hlock   = 2'b00;
    hready  = 1'b0;
    #12;
    chk_rst("reset");
    @(negedge HCLK);
    HRESETn = 1'b1;

    step("first_grant", 2'b11, I, SG, I, SG, 2'b00, 1, 2'b01, 2'b00, 0);
    step("alt1", 2'b11, NS, SG, NS, SG, 2'b00, 1, 2'b10, 2'b01, 0);
    step("alt2", 2'b11, NS, SG, NS, SG, 2'b00, 1, 2'b01, 2'b10, 0);
    step("alt3", 2'b11, NS, SG, NS, SG, 2'b00, 1, 2'b10, 2'b01, 0);

    for (int k = 0; k < 3; k++)
      step("wait_hold", 2'b01, NS, SG, NS, SG, 2'b00, 0, 2'b10, 2'b01, 0);
    step("wait_rel", 2'b01, NS, SG, NS, SG, 2'b00, 1, 2'b01, 2'b10, 0);

    step("incr4_ns", 2'b11, NS, I4, NS, SG, 2'b00, 1, 2'b01, 2'b01, 0);
    step("incr4_s1", 2'b11, S, I4, NS, SG, 2'b00, 1, 2'b01, 2'b01, 0);
    step("incr4_busy", 2'b11, B, I4, NS, SG, 2'b00, 1, 2'b01, 2'b01, 0);
    step("incr4_s2", 2'b11, S, I4, NS, SG, 2'b00, 1, 2'b01, 2'b01, 0);
    step("incr4_end", 2'b11, S, I4, NS, SG, 2'b00, 1, 2'b10, 2'b01, 0);

    step("i8_pre", 2'b11, NS, I8, NS, SG, 2'b00, 1, 2'b01, 2'b10, 0);
    step("i8_ns", 2'b11, NS, I8, NS, SG, 2'b00, 1, 2'b01, 2'b01, 0);
    step("i8_s1", 2'b11, S, I8, NS, SG, 2'b00, 1, 2'b01, 2'b01, 0);
    step("i8_s2", 2'b11, S, I8, NS, SG, 2'b00, 1, 2'b01, 2'b01, 0);
    step("i8_early", 2'b10, I, I8, NS, SG, 2'b00, 1, 2'b10, 2'b01, 0);

    step("m1_i4", 2'b10, I, SG, NS, I4, 2'b00, 1, 2'b10, 2'b10, 0);
    step("m1_idle", 2'b00, I, SG, I, I4, 2'b00, 1, 2'b00, 2'b10, 0);
    step("no_req", 2'b00, I, SG, I, SG, 2'b00, 1, 2'b00, 2'b00, 0);

    step("incr_g", 2'b01, NS, SG, I, SG, 2'b00, 1, 2'b01, 2'b00, 0);
    step("incr_ns", 2'b11, NS, IC, NS, SG, 2'b00, 1, 2'b01, 2'b01, 0);
    step("incr_s1", 2'b11, S, IC, NS, SG, 2'b00, 1, 2'b01, 2'b01, 0);
    step("incr_s2", 2'b11, S, IC, NS, SG, 2'b00, 1, 2'b01, 2'b01, 0);
    step("incr_busy", 2'b11, B, IC, NS, SG, 2'b00, 1, 2'b01, 2'b01, 0);
    step("incr_end", 2'b11, NS, SG, NS, SG, 2'b00, 1, 2'b10, 2'b01, 0);

    step("i16_ns", 2'b11, NS, SG, NS, IX, 2'b00, 1, 2'b10, 2'b10, 0);
    step("i16_s1", 2'b11, NS, SG, S, IX, 2'b00, 1, 2'b10, 2'b10, 0);
    #2;
    HRESETn = 1'b0;
    hready  = 1'b0;
    #1;
    chk_rst("mid_reset");
    @(negedge HCLK);
    HRESETn = 1'b1;
    step("post_rst", 2'b11, I, SG, S, IX, 2'b00, 1, 2'b01, 2'b00, 0);
    step("post_rst2", 2'b11, NS, SG, NS, SG, 2'b00, 1, 2'b10, 2'b01, 0);

`ifdef AHB_ARB_LOCK_EN
    step("lk_grant", 2'b11, NS, SG, NS, SG, 2'b01, 1, 2'b01, 2'b10, 1);
    for (int k = 1; k <= 6; k++)
      step("lk_hold", 2'b11, NS, SG, NS, SG, 2'b01, 1, 2'b01, 2'b01, 1);
`else
    step("lk_grant", 2'b11, NS, SG, NS, SG, 2'b01, 1, 2'b01, 2'b10, 0);
    for (int k = 1; k <= 6; k++)
      step("nolk_alt", 2'b11, NS, SG, NS, SG, 2'b01, 1,
           (k % 2 == 1) ? 2'b10 : 2'b01,
           (k % 2 == 1) ? 2'b01 : 2'b10, 0);
`endif
    step("lk_release", 2'b11, NS, SG, NS, SG, 2'b00, 1, 2'b10, 2'b01, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_si_arbiter.md
AHB_SI_ARBITER -- requirements
Module: ahb_si_arbiter

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 2, meaning number of masters sharing this slave port (2..16).
REQ-002 SHALL have parameter MW, default $clog2(MASTER_NUM), meaning width of the hmaster index.
REQ-003 SHALL have port HCLK  input  1  bus clock; all state updates on its rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset; one clock, asynchronous, active-low.
REQ-005 SHALL have port hreq  input  MASTER_NUM  per-master request (decoder hit for this slave and htrans not IDLE).
REQ-006 SHALL have port htrans  input  MASTER_NUM x 2  per-master HTRANS.
REQ-007 SHALL have port hburst  input  MASTER_NUM x 3  per-master HBURST.
REQ-008 SHALL have port hlock  input  MASTER_NUM  per-master HMASTLOCK request.
REQ-009 SHALL have port hready  input  1  slave HREADYOUT; 1 = current data phase completes this cycle.
REQ-010 SHALL have port addr_sel  output  MASTER_NUM  one-hot (or all-zero) select for the address/control payload mux.
REQ-011 SHALL have port data_sel  output  MASTER_NUM  one-hot (or all-zero) select for the write-data mux, one data phase behind addr_sel.
REQ-012 SHALL have port hmaster  output  MW  binary index of addr_sel owner (0 when addr_sel is zero).
REQ-013 SHALL have port hmastlock  output  1  current address phase is locked.

Function
REQ-014 SHALL implement states IDLE (no owner), OWN (owner, arbitration open), BURST (fixed-length burst in progress), LOCK (locked sequence).
REQ-015 SHALL change addr_sel only on a rising edge with hready=1; with hready=0 all outputs and state SHALL hold.
REQ-016 SHALL arbitrate in IDLE/OWN: winner = first set hreq bit searching upward (wrapping) from last_grant+1; latency one cycle from hreq to addr_sel.
REQ-017 SHALL go to IDLE with addr_sel=0 when no hreq is set at an arbitration point.
REQ-018 SHALL, on an accepted NONSEQ with hburst INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16, load beat counter with 3/7/15 and enter BURST.
REQ-019 SHALL, in BURST, decrement the counter on each accepted SEQ; BUSY SHALL not decrement; counter reaching 0 re-opens arbitration on the same edge.
REQ-020 SHALL treat SINGLE as one beat and undefined-length INCR as held until the owner drives IDLE or NONSEQ.
REQ-021 SHALL re-open arbitration early if the owner drives IDLE mid-burst (early termination); counter cleared.
REQ-022 SHALL update data_sel <= addr_sel on every edge with hready=1.
REQ-023 SHALL update last_grant only when a new owner is granted; simultaneous requests resolve purely by the rotating pointer.

Reset
REQ-024 SHALL, while HRESETn=0, force addr_sel=0, data_sel=0, hmaster=0, hmastlock=0, state IDLE, counter 0, last_grant=MASTER_NUM-1 (master 0 highest priority after reset).
REQ-025 SHALL abandon any burst or lock on reset assertion mid-operation; first grant after release follows REQ-016.

Configuration
REQ-026 SHALL honour macro AHB_ARB_LOCK_EN: defined -> accepted NONSEQ with owner hlock=1 enters LOCK, owner kept until an accepted transfer with hlock=0, hmastlock follows owner hlock.
REQ-027 SHALL, without AHB_ARB_LOCK_EN, ignore hlock, never enter LOCK, tie hmastlock to 0.

Structure
REQ-028 SHALL take HTRANS/HBURST encodings (IDLE, BUSY, NONSEQ, SEQ; SINGLE..INCR16) and the state enum from AHB_package.
REQ-029 SHALL place the rotating one-hot picker in sub-module ahb_rr_pick (inputs req, last_grant; output one-hot grant).

Verification
REQ-030 Reset release, hreq=2'b11 -> cycle 1 addr_sel=01, hmaster=0; next cycle data_sel=01.
REQ-031 M0 SINGLE repeated, M1 requesting continuously -> grants alternate 01,10,01 on consecutive hready edges.
REQ-032 M0 INCR4 NONSEQ+3 SEQ with one BUSY, M1 requesting -> addr_sel=01 for 5 accepted cycles, then 10.
REQ-033 M1 owner, hready=0 for 3 cycles while M0 requests -> addr_sel/data_sel frozen, switch only after hready=1.
REQ-034 M0 INCR8 drives IDLE after beat 3 -> arbitration re-opens that edge, counter 0, M1 granted.
REQ-035 AHB_ARB_LOCK_EN defined, M0 hlock=1 for 6 beats of SINGLE -> hmastlock=1, M1 not granted until M0 hlock=0 transfer accepted.
